// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
//
// Groups the ID-stage instruction description, the EX-stage redirect
// indications and the hazard/stall results exchanged with hazard_scoreboard.
//
// Modports:
//   master : the pipeline side. It drives the ID/EX signals and receives the
//            stall, flush, issue and stall-reason results.
//   slave  : the scoreboard side (hazard_scoreboard). It is the mirror image.
//
// Signals:
//   id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
//   id_rd_addr, id_rd_we, id_class : instruction currently sitting in ID
//   branch_taken, jump             : redirect resolved in EX
//   stall_pipeline, flush_pipeline, issue_fire,
//   stall_raw, stall_waw, stall_struct, stall_count : scoreboard results
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_rd_we;
  logic [1:0]            id_class;
  logic                  branch_taken;
  logic                  jump;

  logic                  stall_pipeline;
  logic                  flush_pipeline;
  logic                  issue_fire;
  logic                  stall_raw;
  logic                  stall_waw;
  logic                  stall_struct;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rd_we, id_class, branch_taken, jump,
    input  stall_pipeline, flush_pipeline, issue_fire,
           stall_raw, stall_waw, stall_struct, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rd_we, id_class, branch_taken, jump,
    output stall_pipeline, flush_pipeline, issue_fire,
           stall_raw, stall_waw, stall_struct, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pending-latency scoreboard that sits beside the ID stage and gates issue
// into EX. Each architectural register carries a countdown of the cycles
// left until its in-flight result becomes forwardable, so loads and
// multi-cycle mul/div results stall dependants for exactly as long as
// needed. It also orders writes to the same register (WAW), blocks a second
// mul/div while the unit is busy, stretches flush after a redirect and
// counts stalled cycles.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; forces all hazard outputs low
//   hz  : hazard_scoreboard_if.slave carrying the ID/EX inputs and the
//         stall_pipeline / flush_pipeline / issue_fire / stall_raw /
//         stall_waw / stall_struct / stall_count outputs
//
// Instruction classes on id_class: 00 ALU, 01 LOAD, 10 MULDIV, 11 as ALU.
// LOAD_LAT and MULDIV_LAT must fit in LAT_W bits; FLUSH_HOLD must be >= 1.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4,
  parameter int FLUSH_HOLD = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_scoreboard_if.slave hz
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int FLUSH_W  = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

  localparam logic [1:0] CLASS_LOAD   = 2'b01;
  localparam logic [1:0] CLASS_MULDIV = 2'b10;

  localparam logic [LAT_W-1:0]   LOAD_LAT_V   = LAT_W'(LOAD_LAT);
  localparam logic [LAT_W-1:0]   MULDIV_LAT_V = LAT_W'(MULDIV_LAT);
  localparam logic [LAT_W-1:0]   LAT_ONE      = LAT_W'(1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT   = FLUSH_W'(FLUSH_HOLD - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE    = FLUSH_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);

  // Entry 0 is held at zero so x0 can never look busy.
  logic [NUM_REGS-1:0][LAT_W-1:0] pending;
  logic [LAT_W-1:0]               muldiv_busy;
  logic [FLUSH_W-1:0]             flush_cnt;
  logic [CNT_W-1:0]               stall_count_q;

  logic [LAT_W-1:0] id_lat;
  logic             id_is_muldiv;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             raw_hazard;
  logic             waw_hazard;
  logic             struct_hazard;
  logic             redirect;
  logic             flush_int;
  logic             stall_int;
  logic             issue_int;

  // Result latency of the instruction in ID; class 11 falls back to ALU.
  always_comb begin
    id_lat = '0;
    case (hz.id_class)
      CLASS_LOAD:   id_lat = LOAD_LAT_V;
      CLASS_MULDIV: id_lat = MULDIV_LAT_V;
      default:      id_lat = '0;
    endcase
  end

  // Hazard detection. WAW only stalls when the older write would land after
  // the new one, i.e. its remaining latency exceeds the new latency. Flush
  // wins over every stall reason, and reset silences everything.
  always_comb begin
    id_is_muldiv  = (hz.id_class == CLASS_MULDIV);

    rs1_hit       = hz.id_rs1_used && (hz.id_rs1_addr != '0) &&
                    (pending[hz.id_rs1_addr] != '0);
    rs2_hit       = hz.id_rs2_used && (hz.id_rs2_addr != '0) &&
                    (pending[hz.id_rs2_addr] != '0);

    raw_hazard    = hz.id_valid && (rs1_hit || rs2_hit);
    waw_hazard    = hz.id_valid && hz.id_rd_we && (hz.id_rd_addr != '0) &&
                    (pending[hz.id_rd_addr] > id_lat);
    struct_hazard = hz.id_valid && id_is_muldiv && (muldiv_busy != '0);

    redirect      = hz.branch_taken || hz.jump;
    flush_int     = !rst && (redirect || (flush_cnt != '0));
    stall_int     = !rst && !flush_int &&
                    (raw_hazard || waw_hazard || struct_hazard);
    issue_int     = !rst && hz.id_valid && !stall_int && !flush_int;
  end

  always_comb begin
    hz.stall_pipeline = stall_int;
    hz.flush_pipeline = flush_int;
    hz.issue_fire     = issue_int;
    hz.stall_raw      = !rst && !flush_int && raw_hazard;
    hz.stall_waw      = !rst && !flush_int && waw_hazard;
    hz.stall_struct   = !rst && !flush_int && struct_hazard;
    hz.stall_count    = stall_count_q;
  end

  // Per-register countdown. A firing writer reloads its destination with the
  // new latency, which takes precedence over the normal decrement. Flushes
  // leave the table alone because older producers are still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_int && hz.id_rd_we && (hz.id_rd_addr == REG_ADDR_W'(r))) begin
          pending[r] <= id_lat;
        end else if (pending[r] != '0) begin
          pending[r] <= pending[r] - LAT_ONE;
        end
      end
    end
  end

  // Mul/div unit occupancy; a new mul/div may only issue once this is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      muldiv_busy <= '0;
    end else if (issue_int && id_is_muldiv) begin
      muldiv_busy <= MULDIV_LAT_V;
    end else if (muldiv_busy != '0) begin
      muldiv_busy <= muldiv_busy - LAT_ONE;
    end
  end

  // Extra flush cycles after a redirect. The redirect cycle itself flushes
  // combinationally, so the counter only covers the remaining FLUSH_HOLD-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (redirect) begin
      flush_cnt <= FLUSH_INIT;
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FLUSH_ONE;
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (stall_int && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_ONE;
    end
  end

endmodule
